// File: rtl/multi_flag_buf_pkg.sv
// ---------------------------------------------------------------------------
// multi_flag_buf_pkg
//   Shared constants for the XADC sample buffer: channel count, sample width,
//   channel-index width and the first out-of-range channel index.
// ---------------------------------------------------------------------------
package multi_flag_buf_pkg;

    localparam int ADC_CH_N   = 13;
    localparam int ADC_DATA_W = 12;
    localparam int ADC_CH_W   = $clog2(ADC_CH_N);

    // First index that addresses no channel; any index >= this is ignored.
    localparam logic [ADC_CH_W-1:0] ILLEGAL_CH = ADC_CH_W'(ADC_CH_N);

endpackage

// File: rtl/multi_flag_buf_chan_flag_cell.sv
// ---------------------------------------------------------------------------
// chan_flag_cell
//   Storage for one buffer channel: sample register, valid flag and sticky
//   overrun bit.
// Ports
//   i_clk      system clock
//   i_reset    asynchronous active-high reset
//   i_set_hit  write i_din and raise the flag
//   i_clr_hit  drop the flag (data kept)
//   i_ovr_clr  clear the overrun bit
//   i_din      sample data
//   o_data     stored sample
//   o_flag     valid flag
//   o_ovr      sticky overrun bit
// ---------------------------------------------------------------------------
module chan_flag_cell #(
    parameter int W = 12
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_set_hit,
    input  logic         i_clr_hit,
    input  logic         i_ovr_clr,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_data,
    output logic         o_flag,
    output logic         o_ovr
);

    logic [W-1:0] r_data;
    logic         r_flag;
    logic         r_ovr;
    logic         w_overrun;

    // A write that lands on an unconsumed sample, unless that sample is
    // being consumed in the same cycle.
    assign w_overrun = i_set_hit & r_flag & ~i_clr_hit;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_data <= '0;
            r_flag <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            if (i_set_hit) begin
                r_data <= i_din;
            end

            // Set has priority over a same-cycle clear.
            if (i_set_hit) begin
                r_flag <= 1'b1;
            end else if (i_clr_hit) begin
                r_flag <= 1'b0;
            end

            // A new overrun has priority over the bulk overrun clear.
            if (w_overrun) begin
                r_ovr <= 1'b1;
            end else if (i_ovr_clr) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign o_data = r_data;
    assign o_flag = r_flag;
    assign o_ovr  = r_ovr;

endmodule

// File: rtl/multi_flag_buf.sv
// ---------------------------------------------------------------------------
// multi_flag_buf
//   N-channel sample buffer between the XADC sequencer and the consumer.
//   Each channel holds one sample plus a valid flag and sticky overrun bit.
//   A round-robin search offers the next pending channel starting just after
//   the most recently cleared one, so a consumer that always clears next_ch
//   visits every pending channel before revisiting any.
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   set_flag/set_ch/din write din into set_ch and raise its flag
//   clr_flag/clr_ch     drop the flag of clr_ch, move round-robin pointer
//   ovr_clr             clear all overrun bits
//   rd_ch/rd_data       combinational read of a channel (0 if out of range)
//   flag_vec/ovr_vec    per-channel valid flags / overrun bits
//   any_flag            any flag raised
//   next_ch/next_valid  next pending channel in round-robin order
// ---------------------------------------------------------------------------
module multi_flag_buf
    import multi_flag_buf_pkg::*;
#(
    parameter  int W  = ADC_DATA_W,
    parameter  int N  = ADC_CH_N,
    localparam int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set_flag,
    input  logic [CW-1:0] set_ch,
    input  logic [W-1:0]  din,
    input  logic          clr_flag,
    input  logic [CW-1:0] clr_ch,
    input  logic          ovr_clr,
    input  logic [CW-1:0] rd_ch,
    output logic [W-1:0]  rd_data,
    output logic [N-1:0]  flag_vec,
    output logic [N-1:0]  ovr_vec,
    output logic          any_flag,
    output logic [CW-1:0] next_ch,
    output logic          next_valid
);

    logic [N-1:0]  w_set_hit;
    logic [N-1:0]  w_clr_hit;
    logic [N-1:0]  w_flag;
    logic [N-1:0]  w_ovr;
    logic [W-1:0]  w_data [N];
    logic          w_clr_valid;
    logic [CW-1:0] w_next_ch;
    logic [W-1:0]  w_rd_data;
    logic [CW-1:0] r_rr_ptr;

    // Index decode; an out-of-range index matches no channel, so the
    // operation is dropped without any explicit range check.
    always_comb begin
        w_set_hit = '0;
        w_clr_hit = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_set_hit[k] = set_flag & (set_ch == CW'(k));
            w_clr_hit[k] = clr_flag & (clr_ch == CW'(k));
        end
    end

    assign w_clr_valid = |w_clr_hit;

    for (genvar g = 0; g < N; g++) begin : g_cell
        chan_flag_cell #(
            .W(W)
        ) u_cell (
            .i_clk     (clk),
            .i_reset   (reset),
            .i_set_hit (w_set_hit[g]),
            .i_clr_hit (w_clr_hit[g]),
            .i_ovr_clr (ovr_clr),
            .i_din     (din),
            .o_data    (w_data[g]),
            .o_flag    (w_flag[g]),
            .o_ovr     (w_ovr[g])
        );
    end

    // Pointer to the last cleared channel; the search starts one past it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= CW'(N - 1);
        end else if (w_clr_valid) begin
            r_rr_ptr <= clr_ch;
        end
    end

    // Rotated priority search: candidates rr_ptr+1 .. rr_ptr+N, modulo N.
    // One extra bit holds the unwrapped sum so a single subtraction wraps it.
    always_comb begin
        logic [CW:0] idx;
        logic        found;
        idx       = '0;
        found     = 1'b0;
        w_next_ch = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = {1'b0, r_rr_ptr} + (CW+1)'(i);
            if (idx >= (CW+1)'(N)) begin
                idx = idx - (CW+1)'(N);
            end
            if (!found && w_flag[idx[CW-1:0]]) begin
                found     = 1'b1;
                w_next_ch = idx[CW-1:0];
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (rd_ch == CW'(k)) begin
                w_rd_data = w_data[k];
            end
        end
    end

    assign rd_data    = w_rd_data;
    assign flag_vec   = w_flag;
    assign ovr_vec    = w_ovr;
    assign any_flag   = |w_flag;
    assign next_valid = |w_flag;
    assign next_ch    = w_next_ch;

endmodule

// File: tb/tb_multi_flag_buf.sv
module tb_multi_flag_buf;
    import multi_flag_buf_pkg::*;

    localparam int W  = ADC_DATA_W;
    localparam int N  = ADC_CH_N;
    localparam int CW = ADC_CH_W;

    logic          clk = 1'b0;
    logic          reset;
    logic          set_flag;
    logic [CW-1:0] set_ch;
    logic [W-1:0]  din;
    logic          clr_flag;
    logic [CW-1:0] clr_ch;
    logic          ovr_clr;
    logic [CW-1:0] rd_ch;
    logic [W-1:0]  rd_data;
    logic [N-1:0]  flag_vec;
    logic [N-1:0]  ovr_vec;
    logic          any_flag;
    logic [CW-1:0] next_ch;
    logic          next_valid;

    typedef struct packed {
        logic [N-1:0]  flag;
        logic [N-1:0]  ovr;
        logic [W-1:0]  rd;
        logic [CW-1:0] nch;
        logic          nv;
        logic          any;
    } snap_t;

    snap_t sb[$];
    snap_t act;
    snap_t e;

    // Reference model state
    logic [W-1:0] m_data [N];
    logic [N-1:0] m_flag;
    logic [N-1:0] m_ovr;
    int           m_rr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign act = {flag_vec, ovr_vec, rd_data, next_ch, next_valid, any_flag};

    multi_flag_buf #(
        .W(W),
        .N(N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .set_flag   (set_flag),
        .set_ch     (set_ch),
        .din        (din),
        .clr_flag   (clr_flag),
        .clr_ch     (clr_ch),
        .ovr_clr    (ovr_clr),
        .rd_ch      (rd_ch),
        .rd_data    (rd_data),
        .flag_vec   (flag_vec),
        .ovr_vec    (ovr_vec),
        .any_flag   (any_flag),
        .next_ch    (next_ch),
        .next_valid (next_valid)
    );

    function automatic int model_next();
        for (int i = 1; i <= N; i++) begin
            if (m_flag[(m_rr + i) % N]) return (m_rr + i) % N;
        end
        return 0;
    endfunction

    function automatic snap_t model_snap(input int rc);
        snap_t s;
        s.flag = m_flag;
        s.ovr  = m_ovr;
        s.rd   = (rc < N) ? m_data[rc] : '0;
        s.nch  = CW'(model_next());
        s.nv   = (m_flag != '0);
        s.any  = (m_flag != '0);
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_data[k] = '0;
        m_flag = '0;
        m_ovr  = '0;
        m_rr   = N - 1;
    endtask

    task automatic idle_inputs();
        set_flag = 1'b0; set_ch = '0; din = '0;
        clr_flag = 1'b0; clr_ch = '0; ovr_clr = 1'b0; rd_ch = '0;
    endtask

    // Drive one cycle of stimulus, push the model's expected post-edge view.
    task automatic drive(input logic s, input int sc, input logic [W-1:0] d,
                         input logic c, input int cc, input logic oc, input int rc);
        logic set_ok, clr_ok;
        set_flag = s; set_ch = CW'(sc); din = d;
        clr_flag = c; clr_ch = CW'(cc); ovr_clr = oc; rd_ch = CW'(rc);
        set_ok = s && (sc < N);
        clr_ok = c && (cc < N);
        if (oc) m_ovr = '0;
        if (set_ok && m_flag[sc] && !(clr_ok && cc == sc)) m_ovr[sc] = 1'b1;
        if (clr_ok) begin m_flag[cc] = 1'b0; m_rr = cc; end
        if (set_ok) begin m_flag[sc] = 1'b1; m_data[sc] = d; end
        sb.push_back(model_snap(rc));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (act !== snap_t'('0)) begin
            n_fail++; $display("FAIL reset_initial: got %h required %h", act, snap_t'('0));
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(1, 3, 12'h333, 0, 0, 0, 3);
        e = sb.pop_front(); n_tests++;
        if (act !== e) begin n_fail++; $display("FAIL reset_wr3: got %h required %h", act, e); end
        drive(1, 7, 12'h777, 0, 0, 0, 7);
        e = sb.pop_front(); n_tests++;
        if (act !== e) begin n_fail++; $display("FAIL reset_wr7: got %h required %h", act, e); end
        // asynchronous reset mid-cycle
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (act !== model_snap(7) || rd_data !== '0) begin
            n_fail++; $display("FAIL reset_midrun: got %h required %h", act, model_snap(7));
        end
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_write();
        drive(1, 5, 12'hABC, 0, 0, 0, 5);
        e = sb.pop_front(); n_tests++;
        if (act !== e) begin n_fail++; $display("FAIL write: got %h required %h", act, e); end
        n_tests++;
        if (flag_vec[5] !== 1'b1 || rd_data !== 12'hABC || next_ch !== 4'd5 || ovr_vec !== '0) begin
            n_fail++; $display("FAIL write_direct: flag5=%b rd=%h nch=%0d ovr=%h required 1 abc 5 0",
                               flag_vec[5], rd_data, next_ch, ovr_vec);
        end
    endtask

    task automatic test_overrun();
        drive(1, 5, 12'h111, 0, 0, 0, 5);
        e = sb.pop_front(); n_tests++;
        if (act !== e) begin n_fail++; $display("FAIL ovr_wr1: got %h required %h", act, e); end
        drive(1, 5, 12'h222, 0, 0, 0, 5);
        e = sb.pop_front(); n_tests++;
        if (act !== e) begin n_fail++; $display("FAIL ovr_wr2: got %h required %h", act, e); end
        n_tests++;
        if (ovr_vec[5] !== 1'b1 || rd_data !== 12'h222) begin
            n_fail++; $display("FAIL ovr_direct: ovr5=%b rd=%h required 1 222", ovr_vec[5], rd_data);
        end
        drive(0, 0, 0, 0, 0, 1, 5);
        e = sb.pop_front(); n_tests++;
        if (act !== e) begin n_fail++; $display("FAIL ovr_clr: got %h required %h", act, e); end
        n_tests++;
        if (ovr_vec !== '0 || flag_vec[5] !== 1'b1) begin
            n_fail++; $display("FAIL ovr_clr_direct: ovr=%h flag5=%b required 0 1", ovr_vec, flag_vec[5]);
        end
        // new overrun in the same cycle as ovr_clr: the new overrun survives
        drive(1, 5, 12'h333, 0, 0, 1, 5);
        e = sb.pop_front(); n_tests++;
        if (act !== e) begin n_fail++; $display("FAIL ovr_vs_clr: got %h required %h", act, e); end
        drive(0, 0, 0, 0, 0, 1, 0);
        e = sb.pop_front(); n_tests++;
        if (act !== e) begin n_fail++; $display("FAIL ovr_clr2: got %h required %h", act, e); end
    endtask

    task automatic test_set_clr_same();
        drive(1, 2, 12'h020, 0, 0, 0, 2);
        e = sb.pop_front(); n_tests++;
        if (act !== e) begin n_fail++; $display("FAIL sc_prep: got %h required %h", act, e); end
        drive(1, 2, 12'h022, 1, 2, 0, 2);
        e = sb.pop_front(); n_tests++;
        if (act !== e) begin n_fail++; $display("FAIL sc_same: got %h required %h", act, e); end
        n_tests++;
        if (flag_vec[2] !== 1'b1 || ovr_vec[2] !== 1'b0 || rd_data !== 12'h022) begin
            n_fail++; $display("FAIL sc_same_direct: flag2=%b ovr2=%b rd=%h required 1 0 022",
                               flag_vec[2], ovr_vec[2], rd_data);
        end
        drive(1, 9, 12'h099, 0, 0, 0, 9);
        e = sb.pop_front(); n_tests++;
        if (act !== e) begin n_fail++; $display("FAIL sc_prep9: got %h required %h", act, e); end
        drive(1, 2, 12'h0A2, 1, 9, 0, 2);
        e = sb.pop_front(); n_tests++;
        if (act !== e) begin n_fail++; $display("FAIL sc_diff: got %h required %h", act, e); end
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < N; k++) begin
            drive(0, 0, 0, 1, k, 1, k);
            e = sb.pop_front(); n_tests++;
            if (act !== e) begin n_fail++; $display("FAIL rr_clrall%0d: got %h required %h", k, act, e); end
        end
        drive(1, 0, 12'h100, 0, 0, 0, 0);
        e = sb.pop_front(); n_tests++;
        if (act !== e) begin n_fail++; $display("FAIL rr_set0: got %h required %h", act, e); end
        drive(1, 12, 12'h1C0, 0, 0, 0, 12);
        e = sb.pop_front(); n_tests++;
        if (act !== e) begin n_fail++; $display("FAIL rr_set12: got %h required %h", act, e); end
        drive(1, 4, 12'h140, 1, 4, 0, 4);
        e = sb.pop_front(); n_tests++;
        if (act !== e || next_ch !== 4'd12) begin
            n_fail++; $display("FAIL rr_ptr4: got %h nch %0d required %h nch 12", act, next_ch, e);
        end
        drive(0, 0, 0, 1, 12, 0, 0);
        e = sb.pop_front(); n_tests++;
        if (act !== e || next_ch !== 4'd0) begin
            n_fail++; $display("FAIL rr_wrap: got %h nch %0d required %h nch 0", act, next_ch, e);
        end
        drive(0, 0, 0, 1, 0, 0, 0);
        e = sb.pop_front(); n_tests++;
        if (act !== e || next_ch !== 4'd4) begin
            n_fail++; $display("FAIL rr_clr0: got %h nch %0d required %h nch 4", act, next_ch, e);
        end
        drive(0, 0, 0, 1, 4, 0, 0);
        e = sb.pop_front(); n_tests++;
        if (act !== e || next_valid !== 1'b0) begin
            n_fail++; $display("FAIL rr_empty: got %h nv %b required %h nv 0", act, next_valid, e);
        end
    endtask

    task automatic test_illegal();
        drive(1, 6, 12'h666, 0, 0, 0, 6);
        e = sb.pop_front(); n_tests++;
        if (act !== e) begin n_fail++; $display("FAIL ill_prep: got %h required %h", act, e); end
        drive(1, 14, 12'hFFF, 1, 15, 0, 13);
        e = sb.pop_front(); n_tests++;
        if (act !== e || rd_data !== '0) begin
            n_fail++; $display("FAIL illegal: got %h required %h", act, e);
        end
        drive(1, int'(ILLEGAL_CH), 12'hEEE, 1, int'(ILLEGAL_CH), 0, 6);
        e = sb.pop_front(); n_tests++;
        if (act !== e) begin n_fail++; $display("FAIL illegal_n: got %h required %h", act, e); end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 300; c++) begin
            logic s, cl, oc;
            s  = ($urandom_range(0, 3) != 0);
            cl = ($urandom_range(0, 2) != 0) && (m_flag != '0);
            oc = ($urandom_range(0, 15) == 0);
            drive(s, $urandom_range(0, 15), W'($urandom), cl, model_next(), oc, $urandom_range(0, 15));
            e = sb.pop_front(); n_tests++;
            if (act !== e) begin n_fail++; $display("FAIL b2b_%0d: got %h required %h", c, act, e); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_overrun();
        test_set_clr_same();
        test_round_robin();
        test_illegal();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
